// File: rtl/core_data_mem_pkg.sv
// core_data_mem_pkg
// Purpose : Shared encodings for the core load/store port (enable_M codes),
//           the responder FSM state codes and small helper functions.
// Ports   : none (package).
package core_data_mem_pkg;

  // enable_M request encodings
  localparam logic [1:0] MEM_IDLE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;
  localparam logic [1:0] MEM_ILL  = 2'b11;

  // Latency counter width; covers the legal LATENCY range 1..15
  localparam int CNT_W = 4;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

  // Counter preload for a given latency: the commit happens when the
  // counter reaches zero, so LATENCY-1 extra BUSY cycles are counted.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
    return CNT_W'(lat - 1);
  endfunction

  // Any non-idle encoding (including the illegal one) is a request
  function automatic logic is_request(input logic [1:0] en);
    return (en != MEM_IDLE);
  endfunction

endpackage

// File: rtl/core_data_mem_if.sv
// core_data_mem_if
// Purpose : Core load/store bus between a Core (master) and its data memory
//           responder (slave).
// Signals : enable_M  - request code (idle/read/write/illegal), master -> slave
//           addr_M    - request address, master -> slave
//           wr_data_M - store data, master -> slave
//           rd_data_M - load data, slave -> master
//           ready_M   - one-cycle completion pulse, slave -> master
interface core_data_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [1:0]            enable_M;
  logic [ADDR_WIDTH-1:0] addr_M;
  logic [DATA_WIDTH-1:0] wr_data_M;
  logic [DATA_WIDTH-1:0] rd_data_M;
  logic                  ready_M;

  modport master (
    output enable_M,
    output addr_M,
    output wr_data_M,
    input  rd_data_M,
    input  ready_M
  );

  modport slave (
    input  enable_M,
    input  addr_M,
    input  wr_data_M,
    output rd_data_M,
    output ready_M
  );
endinterface

// File: rtl/core_data_mem_array.sv
// data_mem_array
// Purpose : 2**ADDR_WIDTH x DATA_WIDTH storage for core_data_mem.
// Ports   : clk, reset      - clock, synchronous active-high reset (read reg only)
//           i_core_we/re    - core commit strobes (write / read)
//           i_core_addr     - core access address
//           i_core_wdata    - core store data
//           o_core_rdata    - registered core load data
//           i_bd_we         - backdoor write strobe
//           i_bd_addr       - backdoor address (write and async read)
//           i_bd_wdata      - backdoor write data
//           o_bd_rdata      - asynchronous read of mem[i_bd_addr]
module data_mem_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_core_we,
  input  logic                  i_core_re,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  input  logic                  i_bd_we,
  input  logic [ADDR_WIDTH-1:0] i_bd_addr,
  input  logic [DATA_WIDTH-1:0] i_bd_wdata,
  output logic [DATA_WIDTH-1:0] o_bd_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port: backdoor first, core last so the core wins when both
  // target the same address on the same edge. Contents are never reset.
  always_ff @(posedge clk) begin
    if (i_bd_we) begin
      r_mem[i_bd_addr] <= i_bd_wdata;
    end
    if (i_core_we) begin
      r_mem[i_core_addr] <= i_core_wdata;
    end
  end

  // Core read register: only updated by a read commit, so writes leave it alone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_core_re) begin
      r_rdata <= r_mem[i_core_addr];
    end
  end

  assign o_core_rdata = r_rdata;
  assign o_bd_rdata   = r_mem[i_bd_addr];

endmodule

// File: rtl/core_data_mem.sv
// core_data_mem
// Purpose : Data-memory responder for one Core's load/store port. Accepts a
//           request, waits LATENCY cycles, commits the access and pulses
//           ready_M for one cycle. Includes a host backdoor port.
// Ports   : clk, reset  - clock, synchronous active-high reset
//           bus         - core_data_mem_if slave (enable/addr/wdata/rdata/ready)
//           err         - sticky illegal-request flag, cleared only by reset
//           bd_we       - backdoor write strobe
//           bd_addr     - backdoor address
//           bd_wdata    - backdoor write data
//           bd_rdata    - asynchronous read of mem[bd_addr]
module core_data_mem
  import core_data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  core_data_mem_if.slave        bus,
  output logic                  err,
  input  logic                  bd_we,
  input  logic [ADDR_WIDTH-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0] bd_wdata,
  output logic [DATA_WIDTH-1:0] bd_rdata
);

  localparam logic [CNT_W-1:0] LAT_PRELOAD = lat_to_cnt(LATENCY);

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ready;
  logic                  r_err;

  logic                  w_commit;
  logic                  w_core_we;
  logic                  w_core_re;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Commit strobe is gated by reset so a reset on the commit edge aborts
  // the access (no write, no read-register update).
  assign w_commit  = (r_state == ST_BUSY) && (r_cnt == '0) && !reset;
  assign w_core_we = w_commit && (r_op == MEM_WR);
  assign w_core_re = w_commit && (r_op == MEM_RD);

  data_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk          (clk),
    .reset        (reset),
    .i_core_we    (w_core_we),
    .i_core_re    (w_core_re),
    .i_core_addr  (r_addr),
    .i_core_wdata (r_wdata),
    .o_core_rdata (w_rdata),
    .i_bd_we      (bd_we),
    .i_bd_addr    (bd_addr),
    .i_bd_wdata   (bd_wdata),
    .o_bd_rdata   (bd_rdata)
  );

  // Request FSM: accept, count down latency, pulse ready, then wait for the
  // request level to drop so a held request is served only once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= MEM_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (is_request(bus.enable_M)) begin
            // Core may drop addr/data after this edge
            r_op    <= bus.enable_M;
            r_addr  <= bus.addr_M;
            r_wdata <= bus.wr_data_M;
            r_cnt   <= LAT_PRELOAD;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // enable_M is deliberately ignored here
          if (r_cnt == '0) begin
            r_ready <= 1'b1;
            if (r_op == MEM_ILL) begin
              r_err <= 1'b1;
            end
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_ready <= 1'b0;
          if (is_request(bus.enable_M)) begin
            r_state <= ST_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          r_ready <= 1'b0;
          if (!is_request(bus.enable_M)) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_M   = r_ready;
  assign bus.rd_data_M = w_rdata;
  assign err           = r_err;

endmodule

// File: tb/tb_core_data_mem.sv
// tb_core_data_mem
// Purpose : Directed self-checking bench for core_data_mem (LATENCY=2).
module tb_core_data_mem;
  import core_data_mem_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int LAT = 2;

  logic          clk;
  logic          reset;
  logic          err;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_wdata;
  logic [DW-1:0] bd_rdata;

  int checks;
  int errors;

  core_data_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  core_data_mem #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .err      (err),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .bd_rdata (bd_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle request and wait (bounded) for ready_M; checks latency.
  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
    int n;
    bus.enable_M  = op;
    bus.addr_M    = a;
    bus.wr_data_M = d;
    tick();
    bus.enable_M  = MEM_IDLE;
    bus.addr_M    = '0;
    bus.wr_data_M = '0;
    n = 0;
    while (bus.ready_M !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, LAT);
  endtask

  initial begin
    int pulses;
    logic [8:0] wide_addr;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bd_we = 1'b0;
    bd_addr = '0;
    bd_wdata = '0;
    bus.enable_M = MEM_IDLE;
    bus.addr_M = '0;
    bus.wr_data_M = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", bus.ready_M, 1'b0);
    check("rst_rdata", bus.rd_data_M, 8'h00);
    check("rst_err", err, 1'b0);

    // Backdoor preload mem[3]=8, then core read
    bd_we = 1'b1; bd_addr = 8'd3; bd_wdata = 8'h08;
    tick();
    bd_we = 1'b0;
    check("bd_preload", bd_rdata, 8'h08);
    do_req(MEM_RD, 8'd3, 8'h00, "rd3");
    check("rd3_ready", bus.ready_M, 1'b1);
    check("rd3_data", bus.rd_data_M, 8'h08);
    tick();
    check("rd3_pulse_len", bus.ready_M, 1'b0);
    check("rd3_data_held", bus.rd_data_M, 8'h08);

    // Write 0x5A to addr 7, visible on backdoor the cycle after commit
    bd_addr = 8'd7;
    do_req(MEM_WR, 8'd7, 8'h5A, "wr7");
    check("wr7_ready", bus.ready_M, 1'b1);
    check("wr7_bd", bd_rdata, 8'h5A);
    check("wr7_rdata_unchanged", bus.rd_data_M, 8'h08);
    tick();
    do_req(MEM_RD, 8'd7, 8'h00, "rd7");
    check("rd7_data", bus.rd_data_M, 8'h5A);
    tick();

    // Level held 10 cycles: one pulse only
    bus.enable_M = MEM_RD; bus.addr_M = 8'd3;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ready_M === 1'b1) pulses++;
    end
    check("hold_pulses", pulses, 1);
    bus.enable_M = MEM_IDLE;
    tick();
    check("hold_no_extra", bus.ready_M, 1'b0);
    do_req(MEM_RD, 8'd3, 8'h00, "rerise");
    check("rerise_data", bus.rd_data_M, 8'h08);
    tick();

    // Illegal request: ready pulses, memory unchanged, err sticky
    bd_addr = 8'd7;
    do_req(MEM_ILL, 8'd7, 8'h33, "ill");
    check("ill_ready", bus.ready_M, 1'b1);
    check("ill_err", err, 1'b1);
    check("ill_mem", bd_rdata, 8'h5A);
    tick();
    tick();
    tick();
    check("ill_err_sticky", err, 1'b1);

    // Reset on the commit edge of a write to addr 9 (old value 4)
    bd_we = 1'b1; bd_addr = 8'd9; bd_wdata = 8'h04;
    tick();
    bd_we = 1'b0;
    bus.enable_M = MEM_WR; bus.addr_M = 8'd9; bus.wr_data_M = 8'hEE;
    tick();
    bus.enable_M = MEM_IDLE; bus.addr_M = '0; bus.wr_data_M = '0;
    tick();
    check("abort_busy_ready", bus.ready_M, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", bus.ready_M, 1'b0);
    check("abort_rdata", bus.rd_data_M, 8'h00);
    check("abort_err", err, 1'b0);
    check("abort_mem", bd_rdata, 8'h04);
    tick();
    check("abort_no_late_ready", bus.ready_M, 1'b0);
    do_req(MEM_RD, 8'd9, 8'h00, "rd9");
    check("rd9_data", bus.rd_data_M, 8'h04);
    tick();

    // Address wrap and core-vs-backdoor collision on addr 0xFF
    wide_addr = 9'h1FF;
    bus.enable_M = MEM_WR; bus.addr_M = wide_addr[7:0]; bus.wr_data_M = 8'h22;
    tick();
    bus.enable_M = MEM_IDLE; bus.addr_M = '0; bus.wr_data_M = '0;
    tick();
    bd_we = 1'b1; bd_addr = 8'hFF; bd_wdata = 8'h11;
    tick();
    bd_we = 1'b0;
    check("coll_ready", bus.ready_M, 1'b1);
    check("coll_core_wins", bd_rdata, 8'h22);
    tick();
    do_req(MEM_RD, 8'hFF, 8'h00, "rdff");
    check("rdff_data", bus.rd_data_M, 8'h22);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
